// File: rtl/wave_replay_buf_pkg.sv
// Shared definitions for the waveform replay buffer: state encodings, default widths
// and the saturating counter helper.
package wave_replay_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PLAY    = 2'd2
  } wave_state_e;

  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 10;
  localparam int FRAC_W_DEF = 16;
  localparam int DROP_CNT_W = 16;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    if (v == {DROP_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/wave_replay_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port, block-RAM style.
module wave_replay_ram #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [0:DEPTH-1];
  logic [DATA_W-1:0] rd_data_r;

  // Write port and registered read port; contents are intentionally never cleared
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    rd_data_r <= mem_r[rd_addr];
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/wave_replay_buf.sv
// Captures one DEPTH-sample frame from the store stage and replays it to the DA path
// through a phase accumulator. Optional frame min/max tracking: WAVE_REPLAY_MINMAX_EN.
module wave_replay_buf
  import wave_replay_buf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     arm,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [ADDR_W+FRAC_W-1:0] rd_step,
  output logic [DATA_W-1:0]        da_data,
  output logic                     da_valid,
  output logic                     capturing,
  output logic                     frame_ready,
  output logic [DROP_CNT_W-1:0]    drop_cnt
`ifdef WAVE_REPLAY_MINMAX_EN
  ,
  output logic [DATA_W-1:0]        frame_min,
  output logic [DATA_W-1:0]        frame_max
`endif
);

  localparam int ACC_W = ADDR_W + FRAC_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  wave_state_e             state_r, state_nxt_s;
  logic [ADDR_W-1:0]       wr_ptr_r;
  logic [ACC_W-1:0]        acc_r;
  logic                    rd_pend_r;
  logic [DATA_W-1:0]       da_data_r;
  logic                    da_valid_r;
  logic                    capturing_r;
  logic                    frame_ready_r;
  logic [DROP_CNT_W-1:0]   drop_cnt_r;
  logic                    ram_we_s;
  logic                    last_wr_s;
  logic                    drop_s;
  logic                    play_s;
  logic [ADDR_W-1:0]       rd_addr_s;
  logic [DATA_W-1:0]       ram_rdata_s;

  // arm overrides everything: a colliding wr_en is neither stored nor counted
  always_comb begin
    state_nxt_s = state_r;
    ram_we_s    = 1'b0;
    last_wr_s   = 1'b0;
    drop_s      = 1'b0;
    if (arm) begin
      state_nxt_s = ST_CAPTURE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          drop_s = wr_en;
        end
        ST_CAPTURE: begin
          ram_we_s = wr_en;
          if (wr_en && (wr_ptr_r == LAST_ADDR)) begin
            last_wr_s   = 1'b1;
            state_nxt_s = ST_PLAY;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end
        ST_PLAY: begin
          drop_s = wr_en;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  assign play_s    = (state_r == ST_PLAY) && !arm;
  assign rd_addr_s = acc_r[ACC_W-1:FRAC_W];

  // Control, write pointer, phase accumulator, output pipeline and drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      capturing_r   <= 1'b0;
      frame_ready_r <= 1'b0;
      wr_ptr_r      <= '0;
      acc_r         <= '0;
      rd_pend_r     <= 1'b0;
      da_valid_r    <= 1'b0;
      da_data_r     <= '0;
      drop_cnt_r    <= '0;
    end else begin
      state_r     <= state_nxt_s;
      capturing_r <= (state_nxt_s == ST_CAPTURE);
      if (arm) begin
        wr_ptr_r      <= '0;
        frame_ready_r <= 1'b0;
      end else if (ram_we_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
        if (last_wr_s) begin
          frame_ready_r <= 1'b1;
        end
      end
      // Accumulator idles at zero so every PLAY entry starts at RAM[0]
      if (play_s) begin
        acc_r <= acc_r + rd_step;
      end else begin
        acc_r <= '0;
      end
      rd_pend_r  <= play_s;
      da_valid_r <= rd_pend_r && !arm;
      if (rd_pend_r && !arm) begin
        da_data_r <= ram_rdata_s;
      end
      if (drop_s) begin
        drop_cnt_r <= sat_inc(drop_cnt_r);
      end
    end
  end

`ifdef WAVE_REPLAY_MINMAX_EN
  logic [DATA_W-1:0] frame_min_r;
  logic [DATA_W-1:0] frame_max_r;

  // Running extremes of the frame being captured
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      frame_min_r <= {DATA_W{1'b1}};
      frame_max_r <= '0;
    end else if (ram_we_s) begin
      if (wr_data < frame_min_r) begin
        frame_min_r <= wr_data;
      end
      if (wr_data > frame_max_r) begin
        frame_max_r <= wr_data;
      end
    end
  end

  assign frame_min = frame_min_r;
  assign frame_max = frame_max_r;
`endif

  wave_replay_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_data),
    .rd_addr (rd_addr_s),
    .rd_data (ram_rdata_s)
  );

  assign da_data     = da_data_r;
  assign da_valid    = da_valid_r;
  assign capturing   = capturing_r;
  assign frame_ready = frame_ready_r;
  assign drop_cnt    = drop_cnt_r;

endmodule

// File: tb/tb_wave_replay_buf.sv
// Self-checking bench for wave_replay_buf: randomized capture/replay against a frame/phase model.
module tb_wave_replay_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_data = 10'd0;
  logic [25:0] rd_step = 26'd0;
  logic [9:0]  da_data;
  logic        da_valid;
  logic        capturing;
  logic        frame_ready;
  logic [15:0] drop_cnt;
`ifdef WAVE_REPLAY_MINMAX_EN
  logic [9:0]  frame_min;
  logic [9:0]  frame_max;
`endif

  wave_replay_buf dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_step     (rd_step),
    .da_data     (da_data),
    .da_valid    (da_valid),
    .capturing   (capturing),
    .frame_ready (frame_ready),
    .drop_cnt    (drop_cnt)
`ifdef WAVE_REPLAY_MINMAX_EN
    ,
    .frame_min   (frame_min),
    .frame_max   (frame_max)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [9:0] m_mem [1024];
  longint     m_acc;
  int         m_q[$];
  int         m_drop;
  logic [9:0] m_last_da;
  int         n_checks;
  int         n_pass;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_drop = 0;
    m_last_da = 10'd0;
    n_checks++; if (da_data !== 10'd0) $display("FAIL reset_da_data: got %0h want 0", da_data); else n_pass++;
    n_checks++; if (da_valid !== 1'b0) $display("FAIL reset_da_valid: got %0b want 0", da_valid); else n_pass++;
    n_checks++; if (capturing !== 1'b0) $display("FAIL reset_capturing: got %0b want 0", capturing); else n_pass++;
    n_checks++; if (frame_ready !== 1'b0) $display("FAIL reset_frame_ready: got %0b want 0", frame_ready); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); else n_pass++;
  endtask

  task automatic test_drops_idle();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 10'($urandom);
      m_drop++;
      tick();
      wr_en = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    n_checks++; if (drop_cnt !== 16'(m_drop)) $display("FAIL idle_drops: got %0d want %0d", drop_cnt, m_drop); else n_pass++;
    n_checks++; if (capturing !== 1'b0) $display("FAIL idle_capturing: got %0b want 0", capturing); else n_pass++;
  endtask

  // Arm (optionally colliding with wr_en), then write a full frame; leaves DUT at PLAY cycle 0
  task automatic do_capture(input bit ramp, input bit gapped, input bit collide);
    int mn;
    int mx;
    logic [9:0] d;
    mn = 1023;
    mx = 0;
    arm = 1'b1;
    wr_en = collide;
    wr_data = 10'($urandom);
    tick();
    arm = 1'b0;
    wr_en = 1'b0;
    n_checks++; if (capturing !== 1'b1) $display("FAIL arm_capturing: got %0b want 1", capturing); else n_pass++;
    n_checks++; if (frame_ready !== 1'b0) $display("FAIL arm_frame_ready: got %0b want 0", frame_ready); else n_pass++;
    n_checks++; if (da_valid !== 1'b0) $display("FAIL arm_da_valid: got %0b want 0", da_valid); else n_pass++;
    n_checks++; if (da_data !== m_last_da) $display("FAIL arm_da_hold: got %0h want %0h", da_data, m_last_da); else n_pass++;
    n_checks++; if (drop_cnt !== 16'(m_drop)) $display("FAIL arm_drop_cnt: got %0d want %0d", drop_cnt, m_drop); else n_pass++;
    for (int i = 0; i < 1024; i++) begin
      if (gapped) begin
        repeat ($urandom_range(0, 2)) tick();
      end
      d = ramp ? 10'(i) : 10'($urandom);
      m_mem[i] = d;
      if (int'(d) < mn) mn = int'(d);
      if (int'(d) > mx) mx = int'(d);
      wr_en = 1'b1;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      if (i == 1022) begin
        n_checks++; if (frame_ready !== 1'b0) $display("FAIL early_frame_ready: got %0b want 0", frame_ready); else n_pass++;
      end
    end
    n_checks++; if (frame_ready !== 1'b1) $display("FAIL frame_ready_rise: got %0b want 1", frame_ready); else n_pass++;
    n_checks++; if (capturing !== 1'b0) $display("FAIL capture_end: got %0b want 0", capturing); else n_pass++;
`ifdef WAVE_REPLAY_MINMAX_EN
    n_checks++; if (frame_min !== 10'(mn)) $display("FAIL frame_min: got %0h want %0h", frame_min, mn); else n_pass++;
    n_checks++; if (frame_max !== 10'(mx)) $display("FAIL frame_max: got %0h want %0h", frame_max, mx); else n_pass++;
`endif
    m_acc = 0;
    m_q.delete();
  endtask

  // Replay n cycles; expected sample = frame[floor(sum of steps / 2^16) mod 1024], 2 cycles late
  task automatic play(input int n, input bit rand_step, input logic [25:0] fixed_step, input bit drops);
    for (int k = 0; k < n; k++) begin
      logic [25:0] st;
      int a;
      st = rand_step ? 26'($urandom) : fixed_step;
      rd_step = st;
      wr_en = drops && ($urandom_range(0, 3) == 0);
      wr_data = 10'($urandom);
      if (wr_en && m_drop < 65535) m_drop++;
      m_q.push_back(int'((m_acc / 65536) % 1024));
      m_acc = (m_acc + longint'(st)) % 67108864;
      tick();
      wr_en = 1'b0;
      if (m_q.size() == 2) begin
        a = m_q.pop_front();
        n_checks++;
        if (da_valid !== 1'b1 || da_data !== m_mem[a])
          $display("FAIL play_sample: cycle %0d got valid=%0b data=%0h want valid=1 data=%0h (addr %0d)",
                   k, da_valid, da_data, m_mem[a], a);
        else n_pass++;
        m_last_da = m_mem[a];
      end else begin
        n_checks++; if (da_valid !== 1'b0) $display("FAIL play_first_valid: got %0b want 0", da_valid); else n_pass++;
      end
    end
    n_checks++; if (drop_cnt !== 16'(m_drop)) $display("FAIL play_drop_cnt: got %0d want %0d", drop_cnt, m_drop); else n_pass++;
  endtask

  task automatic test_ramp();
    rd_step = 26'h10000;
    do_capture(1'b1, 1'b0, 1'b0);
    play(1030, 1'b0, 26'h10000, 1'b0);
  endtask

  task automatic test_half_rate();
    play(2100, 1'b0, 26'h08000, 1'b0);
  endtask

  task automatic test_rearm_mid_play();
    play(int'($urandom_range(20, 80)), 1'b1, 26'd0, 1'b1);
    do_capture(1'b0, 1'b1, 1'b1);
    play(12, 1'b0, 26'd0, 1'b0);
    play(600, 1'b1, 26'd0, 1'b1);
  endtask

  task automatic test_reset_mid_capture();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 300; i++) begin
      wr_en = 1'b1;
      wr_data = 10'($urandom);
      tick();
    end
    wr_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_drop = 0;
    m_last_da = 10'd0;
    n_checks++; if (capturing !== 1'b0) $display("FAIL rst_cap_capturing: got %0b want 0", capturing); else n_pass++;
    n_checks++; if (frame_ready !== 1'b0) $display("FAIL rst_cap_frame_ready: got %0b want 0", frame_ready); else n_pass++;
    n_checks++; if (da_valid !== 1'b0) $display("FAIL rst_cap_da_valid: got %0b want 0", da_valid); else n_pass++;
    n_checks++; if (da_data !== 10'd0) $display("FAIL rst_cap_da_data: got %0h want 0", da_data); else n_pass++;
    n_checks++; if (drop_cnt !== 16'd0) $display("FAIL rst_cap_drop_cnt: got %0d want 0", drop_cnt); else n_pass++;
    do_capture(1'b0, 1'b0, 1'b0);
    play(300, 1'b1, 26'd0, 1'b1);
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    m_acc = 0;
    test_reset();
    test_drops_idle();
    test_ramp();
    test_half_rate();
    test_rearm_mid_play();
    test_reset_mid_capture();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
